// File: rtl/fetch.sv
// In-order instruction fetch: drives a one-cycle-latency instruction memory and
// buffers returned words in a 2-entry FIFO feeding decode; redirects flush everything.
module fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] instr_out,
    input  logic            ready_in
);

    logic [XLEN-1:0] pc_q;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic [1:0]      occ;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [XLEN-1:0] fifo_pc    [2];
    logic [XLEN-1:0] fifo_instr [2];

    logic            fire;
    logic            enq;
    logic            issue;
    logic [2:0]      credit;
    logic            unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    // A request is only issued if its data is guaranteed a FIFO slot on return.
    assign fire   = valid_out && ready_in;
    assign enq    = inflight_q && !redirect_valid;
    assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, fire};
    assign issue  = rst_n && !redirect_valid && (credit < 3'd2);

    assign imem_req_valid = issue;
    assign imem_addr      = pc_q;

    assign valid_out = (occ != 2'd0);
    assign pc_out    = fifo_pc[rd_ptr];
    assign instr_out = fifo_instr[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            occ           <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight_q <= 1'b0;
            occ        <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + {{(XLEN-3){1'b0}}, 3'd4};
            end
            if (enq) begin
                wr_ptr <= ~wr_ptr;
            end
            if (fire) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, enq} - {1'b0, fire};
        end
    end

    // Payload storage needs no reset; it is only observed while valid_out is high.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_pc[wr_ptr]    <= inflight_pc_q;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            assert (occ != 2'd2);
        end
    end

endmodule

// File: doc/fetch.md
# fetch

In-order instruction fetch unit that produces the `valid`/`pc`/`instr` stream consumed by the decode stage. It maintains the fetch PC and issues reads to a synchronous instruction memory with one-cycle read latency. Returned words are buffered in a 2-entry FIFO so that decode back-pressure never loses an in-flight read. A redirect from the branch unit flushes all buffered and in-flight work and restarts fetch at the new PC.

## Interface

Parameters:
- `XLEN`, 32: data and address width. Only 32 is supported.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  read request this cycle. Memory always accepts.
- `imem_addr`  out  32  read address. Bits [1:0] are always 0.
- `imem_rdata`  in  32  read data for the request made in the previous cycle.
- `redirect_valid`  in  1  single-cycle restart pulse from the branch unit (BNE/JALR resolution).
- `redirect_pc`  in  32  restart address. Bits [1:0] are ignored and treated as 0.
- `valid_out`  out  1  FIFO head is valid.
- `pc_out`  out  32  PC of the FIFO head.
- `instr_out`  out  32  instruction of the FIFO head.
- `ready_in`  in  1  consumer accepts the head. A transfer (`fire`) occurs when `valid_out && ready_in`.

## Operation

State:
- `pc_q` (32): next address to fetch.
- `inflight_q` (1) and `inflight_pc_q` (32): the outstanding request and its address.
- 2-entry FIFO of {pc, instr} with occupancy `occ` (0..2).

Issue rule:
- `imem_req_valid = rst_n && !redirect_valid && (occ + inflight_q - fire) < 2`.
- `imem_addr = pc_q`.
- On issue: `pc_q <= pc_q + 4`, computed modulo 2^32 so 0xFFFF_FFFC wraps to 0. Also `inflight_q <= 1` and `inflight_pc_q <= pc_q`. With no issue, `inflight_q <= 0`.

Return rule:
- When `inflight_q` is set and `redirect_valid` is low, enqueue {`inflight_pc_q`, `imem_rdata`} this cycle.
- The credit rule guarantees the FIFO never overflows. An enqueue into a full FIFO is an assertion failure.

Dequeue and simultaneous events:
- `fire` pops the head.
- Enqueue and dequeue may occur in the same cycle. `occ` is then unchanged and order is preserved.

Redirect, in the cycle `redirect_valid` is high:
- No request is issued.
- Any `imem_rdata` arriving that cycle is discarded.
- At the edge: FIFO flushed (`occ <= 0`), `inflight_q <= 0`, `pc_q <= {redirect_pc[31:2], 2'b00}`.
- A `fire` in the redirect cycle is still a valid transfer. Discarding that instruction is downstream's responsibility.

Outputs:
- `valid_out = (occ != 0)`. `pc_out` and `instr_out` come from the FIFO head and are driven only by registered state.
- Payload is don't-care when `valid_out` is 0.

Reset:
- Asserting `rst_n` low at any time, including mid-stream, immediately sets `pc_q = RESET_PC`, `occ = 0` and `inflight_q = 0`.
- Therefore `valid_out = 0` and `imem_req_valid = 0` while reset is held.

## Timing

- Cycle 0 is the first cycle with `rst_n` high. It issues `RESET_PC`. Cycle 1 issues `RESET_PC+4`. Cycle 2 asserts `valid_out` with `pc_out = RESET_PC`.
- Fetch-to-valid latency is 2 cycles. Redirect at cycle t gives a request at t+1 and `valid_out` at t+3 with `pc_out` equal to the redirect target.
- Steady-state throughput is 1 instruction per cycle with `ready_in` held high.
- Back-pressure fills the FIFO to 2 with no in-flight request, and issue stops. When `ready_in` rises, issue resumes in the same cycle and no bubble appears at the output.
- `valid_out`, `pc_out` and `instr_out` hold stable while `valid_out && !ready_in`, unless a redirect or reset occurs.

## Test plan

- **Startup:** release reset with `RESET_PC=0`, memory word(a) = a ^ 0xA5A5_0000, `ready_in=1` -> `valid_out` first high at cycle 2. Outputs are pc 0x0, 0x4, 0x8… one per cycle with matching instr.
- **Back-pressure:** drop `ready_in` for 5 cycles after the first transfer -> `imem_req_valid` low once `occ=2`. The head holds pc 0x4 unchanged. After release, pc 0x4, 0x8, 0xC follow back-to-back with no gap or duplicate.
- **Redirect with in-flight request:** pulse `redirect_valid` with `redirect_pc=0x100` while `occ=1` and `inflight_q=1` -> no `imem_req_valid` that cycle. Next cycle `imem_addr=0x100`. The next output pc is 0x100, and no pre-redirect PC appears after the redirect edge.
- **Redirect while full and stalled:** `ready_in=0`, `occ=2`, redirect to 0x203 -> flush, then fetch from 0x200. The first `valid_out` is 3 cycles after the redirect with pc 0x200.
- **PC wrap:** redirect to 0xFFFF_FFFC -> outputs pc 0xFFFF_FFFC, then 0x0000_0000.
- **Reset mid-stream:** assert `rst_n` low while `occ=2` -> `valid_out` and `imem_req_valid` go to 0 immediately, without a clock. After release, the startup sequence from `RESET_PC` repeats exactly.
